// File: rtl/pedometer_pkg.sv
// Shared types and defaults for the pedometer command scheduler.
// State encoding, command kinds, operand widths and the default WAIT timeout.
package pedometer_pkg;

  localparam int unsigned STEP_W_DEF  = 16;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned ADDR_W      = 3;
  localparam int unsigned DATA_W      = 8;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWrite = 3'd1,
    StRun   = 3'd2,
    StWait  = 3'd3,
    StDone  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CmdCount  = 2'd0,
    CmdSingle = 2'd1,
    CmdDual   = 2'd2
  } cmd_e;

  // Highest-priority request wins; the rest are dropped.
  function automatic cmd_e select_cmd(input logic dual, input logic single);
    if (dual) begin
      return CmdDual;
    end else if (single) begin
      return CmdSingle;
    end
    return CmdCount;
  endfunction

endpackage

// File: rtl/ped_step_counter.sv
// Saturating step counter: increments on inc, sticks at all-ones, clear wins.
module ped_step_counter
  import pedometer_pkg::*;
#(
  parameter int unsigned W = STEP_W_DEF
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = &r_count;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pedometer_sched.sv
// Command scheduler for weight writes and step classification.
// Optional WAIT timeout with sticky error flag is enabled by defining PED_TIMEOUT_EN.
module pedometer_sched
  import pedometer_pkg::*;
#(
  parameter int unsigned STEP_W  = STEP_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              countSteps,
  input  logic              updateWeights,
  input  logic              dualUpdateWeights,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [ADDR_W-1:0] Addr2,
  input  logic [DATA_W-1:0] Data1,
  input  logic [DATA_W-1:0] Data2,
  input  logic              coreDone,
  input  logic              coreStep,
  output logic              cmdAccept,
  output logic              busy,
  output logic              wrEn1,
  output logic              wrEn2,
  output logic [ADDR_W-1:0] wrAddr1,
  output logic [ADDR_W-1:0] wrAddr2,
  output logic [DATA_W-1:0] wrData1,
  output logic [DATA_W-1:0] wrData2,
  output logic              coreStart,
  output logic [DATA_W-1:0] coreA,
  output logic [DATA_W-1:0] coreB,
  output logic [STEP_W-1:0] stepCount,
  output logic              done,
  output logic              timeoutErr
);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_e            r_state;
  state_e            w_state_next;
  cmd_e              r_cmd;
  cmd_e              w_cmd_sel;

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [ADDR_W-1:0] r_addr1;
  logic [ADDR_W-1:0] r_addr2;
  logic [DATA_W-1:0] r_data1;
  logic [DATA_W-1:0] r_data2;

  logic              r_cmd_accept;
  logic              r_wr_en1;
  logic              r_wr_en2;
  logic              r_core_start;
  logic              r_done;

  logic              w_req_any;
  logic              w_accept;
  logic              w_wr_en1;
  logic              w_wr_en2;
  logic              w_core_start;
  logic              w_done;
  logic              w_inc;
  logic              w_timeout;

  assign w_req_any = countSteps | updateWeights | dualUpdateWeights;
  assign w_cmd_sel = select_cmd(dualUpdateWeights, updateWeights);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_wr_en1     = 1'b0;
    w_wr_en2     = 1'b0;
    w_core_start = 1'b0;
    w_done       = 1'b0;
    w_inc        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req_any) begin
          w_accept     = 1'b1;
          w_state_next = (w_cmd_sel == CmdCount) ? StRun : StWrite;
        end
      end
      StWrite: begin
        // On a same-address dual write only port 2 fires, so Data2 wins.
        w_wr_en1     = (r_cmd == CmdSingle) || (r_addr1 != r_addr2);
        w_wr_en2     = (r_cmd == CmdDual);
        w_state_next = StDone;
      end
      StRun: begin
        w_core_start = 1'b1;
        w_state_next = StWait;
      end
      StWait: begin
        if (coreDone) begin
          w_inc        = coreStep;
          w_state_next = StDone;
        end else if (w_timeout) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Strobes are registered, so each appears one cycle after its state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_cmd        <= CmdCount;
      r_a          <= '0;
      r_b          <= '0;
      r_addr1      <= '0;
      r_addr2      <= '0;
      r_data1      <= '0;
      r_data2      <= '0;
      r_cmd_accept <= 1'b0;
      r_wr_en1     <= 1'b0;
      r_wr_en2     <= 1'b0;
      r_core_start <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cmd_accept <= w_accept;
      r_wr_en1     <= w_wr_en1;
      r_wr_en2     <= w_wr_en2;
      r_core_start <= w_core_start;
      r_done       <= w_done;
      if (w_accept) begin
        r_cmd   <= w_cmd_sel;
        r_a     <= A;
        r_b     <= B;
        r_addr1 <= Addr1;
        r_addr2 <= Addr2;
        r_data1 <= Data1;
        r_data2 <= Data2;
      end
    end
  end

`ifdef PED_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] r_wait_cnt;
  logic            r_timeout_err;

  assign w_timeout = (r_state == StWait) && !coreDone && (r_wait_cnt == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((r_state == StWait) && !coreDone && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + CntW'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeoutErr = r_timeout_err;
`else
  assign w_timeout  = 1'b0;
  assign timeoutErr = 1'b0;
`endif

  ped_step_counter #(
    .W (STEP_W)
  ) u_step_counter (
    .clk   (clk),
    .clear (reset),
    .inc   (w_inc),
    .count (stepCount)
  );

  assign cmdAccept = r_cmd_accept;
  assign busy      = (r_state != StIdle);
  assign wrEn1     = r_wr_en1;
  assign wrEn2     = r_wr_en2;
  assign wrAddr1   = r_addr1;
  assign wrAddr2   = r_addr2;
  assign wrData1   = r_data1;
  assign wrData2   = r_data2;
  assign coreStart = r_core_start;
  assign coreA     = r_a;
  assign coreB     = r_b;
  assign done      = r_done;

endmodule

// File: tb/tb_pedometer_sched.sv
// Directed bench for pedometer_sched; a second instance with STEP_W=2 exercises saturation.
// Timeout scenario follows PED_TIMEOUT_EN.
module tb_pedometer_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       countSteps, updateWeights, dualUpdateWeights;
  logic [7:0] A, B, Data1, Data2;
  logic [2:0] Addr1, Addr2;
  logic       coreDone, coreStep;

  logic        cmdAccept, busy, wrEn1, wrEn2, coreStart, done, timeoutErr;
  logic [2:0]  wrAddr1, wrAddr2;
  logic [7:0]  wrData1, wrData2, coreA, coreB;
  logic [15:0] stepCount;

  logic        s_cmdAccept, s_busy, s_wrEn1, s_wrEn2, s_coreStart, s_done, s_timeoutErr;
  logic [2:0]  s_wrAddr1, s_wrAddr2;
  logic [7:0]  s_wrData1, s_wrData2, s_coreA, s_coreB;
  logic [1:0]  s_stepCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pedometer_sched dut (
    .clk (clk), .reset (reset), .countSteps (countSteps), .updateWeights (updateWeights),
    .dualUpdateWeights (dualUpdateWeights), .A (A), .B (B), .Addr1 (Addr1), .Addr2 (Addr2),
    .Data1 (Data1), .Data2 (Data2), .coreDone (coreDone), .coreStep (coreStep),
    .cmdAccept (cmdAccept), .busy (busy), .wrEn1 (wrEn1), .wrEn2 (wrEn2),
    .wrAddr1 (wrAddr1), .wrAddr2 (wrAddr2), .wrData1 (wrData1), .wrData2 (wrData2),
    .coreStart (coreStart), .coreA (coreA), .coreB (coreB), .stepCount (stepCount),
    .done (done), .timeoutErr (timeoutErr)
  );

  pedometer_sched #(
    .STEP_W (2)
  ) dut_sat (
    .clk (clk), .reset (reset), .countSteps (countSteps), .updateWeights (updateWeights),
    .dualUpdateWeights (dualUpdateWeights), .A (A), .B (B), .Addr1 (Addr1), .Addr2 (Addr2),
    .Data1 (Data1), .Data2 (Data2), .coreDone (coreDone), .coreStep (coreStep),
    .cmdAccept (s_cmdAccept), .busy (s_busy), .wrEn1 (s_wrEn1), .wrEn2 (s_wrEn2),
    .wrAddr1 (s_wrAddr1), .wrAddr2 (s_wrAddr2), .wrData1 (s_wrData1), .wrData2 (s_wrData2),
    .coreStart (s_coreStart), .coreA (s_coreA), .coreB (s_coreB), .stepCount (s_stepCount),
    .done (s_done), .timeoutErr (s_timeoutErr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One countSteps command with coreDone returned in the first WAIT cycle.
  task automatic run_count(input logic step, input logic [31:0] exp_big,
                           input logic [31:0] exp_small);
    countSteps = 1'b1;
    tick();
    countSteps = 1'b0;
    chk("cnt_accept", cmdAccept, 1);
    tick();
    chk("cnt_start", coreStart, 1);
    coreDone = 1'b1;
    coreStep = step;
    tick();
    coreDone = 1'b0;
    coreStep = 1'b0;
    chk("cnt_no_done_early", done, 0);
    chk("cnt_big", stepCount, exp_big);
    chk("cnt_small", s_stepCount, exp_small);
    tick();
    chk("cnt_done_lat4", done, 1);
    tick();
    chk("cnt_done_pulse", done, 0);
  endtask

  initial begin
    reset = 1'b1;
    countSteps = 0; updateWeights = 0; dualUpdateWeights = 0;
    A = 0; B = 0; Addr1 = 0; Addr2 = 0; Data1 = 0; Data2 = 0;
    coreDone = 0; coreStep = 0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_count", stepCount, 0);
    chk("rst_accept", cmdAccept, 0);
    chk("rst_done", done, 0);
    chk("rst_wren", {wrEn1, wrEn2}, 0);
    chk("rst_terr", timeoutErr, 0);
    reset = 1'b0;
    tick();

    // Single write
    updateWeights = 1; Addr1 = 3'd5; Data1 = 8'h3C; Addr2 = 3'd1; Data2 = 8'hAA;
    tick();
    updateWeights = 0;
    chk("w1_accept", cmdAccept, 1);
    chk("w1_busy", busy, 1);
    chk("w1_wren_early", wrEn1, 0);
    tick();
    chk("w1_accept_pulse", cmdAccept, 0);
    chk("w1_wren", {wrEn1, wrEn2}, 2'b10);
    chk("w1_addr", wrAddr1, 5);
    chk("w1_data", wrData1, 8'h3C);
    tick();
    chk("w1_wren_off", wrEn1, 0);
    chk("w1_done", done, 1);
    tick();
    chk("w1_done_pulse", done, 0);
    chk("w1_hold_addr", wrAddr1, 5);

    // Dual write wins over the other two requests
    dualUpdateWeights = 1; updateWeights = 1; countSteps = 1;
    Addr1 = 3'd2; Data1 = 8'h11; Addr2 = 3'd6; Data2 = 8'h22; A = 8'h99;
    tick();
    dualUpdateWeights = 0; updateWeights = 0; countSteps = 0;
    chk("d_accept", cmdAccept, 1);
    tick();
    chk("d_wren", {wrEn1, wrEn2}, 2'b11);
    chk("d_addrs", {wrAddr1, wrAddr2}, {3'd2, 3'd6});
    chk("d_datas", {wrData1, wrData2}, 16'h1122);
    chk("d_no_start", coreStart, 0);
    tick();
    chk("d_done", done, 1);
    chk("d_no_start2", coreStart, 0);
    tick();
    chk("d_idle", busy, 0);

    // Dual write to the same address
    dualUpdateWeights = 1; Addr1 = 3'd4; Addr2 = 3'd4; Data1 = 8'h55; Data2 = 8'h7F;
    tick();
    dualUpdateWeights = 0;
    tick();
    chk("same_wren", {wrEn1, wrEn2}, 2'b01);
    chk("same_data2", wrData2, 8'h7F);
    chk("same_addr2", wrAddr2, 4);
    tick();
    chk("same_done", done, 1);
    tick();

    // countSteps with coreDone after 5 cycles
    countSteps = 1; A = 8'h10; B = 8'h20;
    tick();
    countSteps = 0;
    chk("c_accept", cmdAccept, 1);
    chk("c_coreA", coreA, 8'h10);
    chk("c_coreB", coreB, 8'h20);
    chk("c_start_early", coreStart, 0);
    tick();
    chk("c_start", coreStart, 1);
    tick();
    chk("c_start_once", coreStart, 0);
    tick();
    tick();
    chk("c_wait_busy", busy, 1);
    chk("c_wait_nodone", done, 0);
    chk("c_wait_count", stepCount, 0);
    coreDone = 1; coreStep = 1;
    tick();
    coreDone = 0; coreStep = 0;
    chk("c_count1", stepCount, 1);
    chk("c_done_early", done, 0);
    tick();
    chk("c_done", done, 1);
    chk("c_start_never", coreStart, 0);
    tick();
    chk("c_done_pulse", done, 0);

    // coreDone while idle is ignored
    coreDone = 1; coreStep = 1;
    tick();
    tick();
    coreDone = 0; coreStep = 0;
    chk("idle_coredone", stepCount, 1);
    chk("idle_busy", busy, 0);

    // Saturation on the 2-bit instance; a no-step result leaves counts alone
    run_count(1'b1, 2, 2);
    run_count(1'b0, 2, 2);
    run_count(1'b1, 3, 3);
    run_count(1'b1, 4, 3);

    // Reset in WAIT; a request while busy is ignored
    countSteps = 1; A = 8'h42;
    tick();
    countSteps = 0;
    tick();
    updateWeights = 1; Addr1 = 3'd7;
    tick();
    chk("busy_ignore_acc", cmdAccept, 0);
    tick();
    chk("busy_ignore_wr", wrEn1, 0);
    updateWeights = 0;
    reset = 1;
    tick();
    chk("rw_busy", busy, 0);
    chk("rw_count", stepCount, 0);
    chk("rw_small", s_stepCount, 0);
    chk("rw_coreA", coreA, 0);
    chk("rw_addr", wrAddr1, 0);
    reset = 0;
    tick();
    chk("rw_idle", busy, 0);

`ifdef PED_TIMEOUT_EN
    countSteps = 1;
    tick();
    countSteps = 0;
    tick();
    repeat (254) tick();
    chk("to_not_yet", timeoutErr, 0);
    chk("to_still_wait", busy, 1);
    tick();
    chk("to_err", timeoutErr, 1);
    chk("to_done_early", done, 0);
    tick();
    chk("to_done", done, 1);
    chk("to_count", stepCount, 0);
    tick();
    tick();
    chk("to_sticky", timeoutErr, 1);
    reset = 1;
    tick();
    chk("to_rst", timeoutErr, 0);
    reset = 0;
    tick();
`else
    countSteps = 1;
    tick();
    countSteps = 0;
    repeat (300) tick();
    chk("nto_err", timeoutErr, 0);
    chk("nto_wait", busy, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("nto_rst", busy, 0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pedometer_sched.md
PEDOMETER_SCHED -- requirements
Module: pedometer_sched

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- STEP_W, 16, step counter width.
- TIMEOUT, 255, maximum cycles in WAIT before abort (used only with PED_TIMEOUT_EN).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- countSteps  in  1  level request to classify one sample.
- updateWeights  in  1  level request for a single weight write.
- dualUpdateWeights  in  1  level request for a two-port weight write.
- A, B  in  8 each  sample operands for countSteps.
- Addr1, Addr2  in  3 each  weight register addresses.
- Data1, Data2  in  8 each  weight write data.
- coreDone  in  1  core pulse: classification finished.
- coreStep  in  1  core result, valid with coreDone: step detected.
- cmdAccept  out  1  one-cycle pulse: request latched.
- busy  out  1  high in every state except IDLE.
- wrEn1/wrEn2  out  1 each  register-file write enables.
- wrAddr1/wrAddr2  out  3 each  write addresses.
- wrData1/wrData2  out  8 each  write data.
- coreStart  out  1  one-cycle start pulse to the core.
- coreA, coreB  out  8 each  latched operands to the core.
- stepCount  out  STEP_W  accumulated steps.
- done  out  1  one-cycle completion pulse.
- timeoutErr  out  1  sticky abort flag.

Function
REQ-003 States SHALL be IDLE, WRITE, RUN, WAIT, DONE.
REQ-004 In IDLE, with any request high at edge N, the block SHALL latch all operands, pulse cmdAccept at N+1, and leave IDLE.
REQ-005 Priority SHALL be dualUpdateWeights > updateWeights > countSteps; lower requests present at the same edge SHALL be dropped, not queued.
REQ-006 Requests outside IDLE SHALL be ignored.
REQ-007 updateWeights SHALL go to WRITE and assert wrEn1 for exactly one cycle with latched Addr1/Data1; wrEn2=0.
REQ-008 dualUpdateWeights SHALL go to WRITE and assert wrEn1 and wrEn2 in the same cycle.
REQ-009 In a dual write with Addr1==Addr2, only wrEn2 SHALL assert (Data2 wins).
REQ-010 WRITE SHALL be followed by DONE.
REQ-011 countSteps SHALL go to RUN, which asserts coreStart for one cycle with latched coreA/coreB, then WAIT.
REQ-012 WAIT SHALL hold until coreDone=1, then go to DONE.
REQ-013 On coreDone with coreStep=1, stepCount SHALL increment by 1, saturating at 2^STEP_W-1.
REQ-014 coreDone outside WAIT SHALL be ignored.
REQ-015 DONE SHALL pulse done for one cycle, then go to IDLE. Minimum command-to-done latency: 3 cycles for writes, 4 cycles for countSteps with immediate coreDone.
REQ-016 coreA/coreB and wrAddr/wrData SHALL hold their last latched values when not in use; enables SHALL be 0 outside WRITE.

Reset
REQ-017 reset SHALL override all activity, including mid-operation: state=IDLE, and every output and counter SHALL be 0.

Configuration
REQ-018 With PED_TIMEOUT_EN defined:
- a cycle counter SHALL run in WAIT;
- on reaching TIMEOUT cycles without coreDone, the block SHALL set timeoutErr (sticky until reset) and go to DONE with stepCount unchanged.
REQ-019 Without PED_TIMEOUT_EN, WAIT SHALL have no timeout and timeoutErr SHALL be tied to 0.

Structure
REQ-020 State encoding, widths and the default TIMEOUT SHALL reside in the shared package pedometer_pkg.
REQ-021 The saturating counter SHALL be the sub-module ped_step_counter (inputs inc and clear; output count).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- updateWeights, Addr1=5, Data1=0x3C -> cmdAccept at N+1, wrEn1=1 wrAddr1=5 wrData1=0x3C for one cycle, done at N+3.
- dualUpdateWeights with updateWeights and countSteps in the same cycle, Addr1=2/Data1=0x11, Addr2=6/Data2=0x22 -> both writes in one cycle; no coreStart.
- dualUpdateWeights, Addr1=Addr2=4, Data2=0x7F -> only wrEn2, wrData2=0x7F.
- countSteps, A=0x10 B=0x20, coreDone+coreStep after 5 cycles -> coreStart once, coreA=0x10, stepCount 0->1, done one cycle later; starting from stepCount=0xFFFF, the count stays at 0xFFFF.
- reset asserted in WAIT -> next cycle IDLE, busy=0, stepCount=0; with PED_TIMEOUT_EN and no coreDone -> timeoutErr=1 after 255 WAIT cycles, then done.
